// File: rtl/roulette_pkg.sv
// roulette_pkg: state codes, keypad codes and key-class helpers for the roulette controller
package roulette_pkg;
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_BET_AMOUNT = 4'd1,
        S_BET_COUNT  = 4'd2,
        S_NUM_INPUT  = 4'd3,
        S_START_SPIN = 4'd4,
        S_SPIN_WAIT  = 4'd5,
        S_RESULT     = 4'd6,
        S_WIN_DISP   = 4'd7,
        S_LOSE_DISP  = 4'd8,
        S_SETTLE     = 4'd9,
        S_CHECK_OVER = 4'd10,
        S_GAME_OVER  = 4'd11
    } state_t;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction
    function automatic logic is_star(input logic [3:0] k);
        return k == KEY_STAR;
    endfunction
    function automatic logic is_hash(input logic [3:0] k);
        return k == KEY_HASH;
    endfunction
    function automatic logic [3:0] odds(input int slots, input int cnt);
        return (cnt == 0) ? 4'd0 : 4'(slots / cnt);
    endfunction
endpackage

// File: rtl/roulette_bet_match.sv
// roulette_bet_match: matches the result number and a candidate digit against the bet store
module roulette_bet_match #(
    parameter int MAX_BETS = 4
) (
    input  logic [3:0]                    nums [MAX_BETS],
    input  logic [$clog2(MAX_BETS+1)-1:0] bet_count,
    input  logic [$clog2(MAX_BETS+1)-1:0] idx,
    input  logic [3:0]                    result_num,
    input  logic [3:0]                    cand,
    output logic                          hit,
    output logic                          dup
);
    localparam int CW = $clog2(MAX_BETS + 1);
    always_comb begin
        hit = 1'b0;
        dup = 1'b0;
        for (int i = 0; i < MAX_BETS; i++) begin
            hit = hit | (CW'(i) < bet_count && nums[i] == result_num);
            dup = dup | (CW'(i) < idx && nums[i] == cand);
        end
    end
endmodule

// File: rtl/roulette_game_ctrl.sv
// roulette_game_ctrl: keypad roulette round controller; ROULETTE_SPIN_TIMEOUT_EN adds a spin watchdog
module roulette_game_ctrl
    import roulette_pkg::*;
#(
    parameter int NUM_SLOTS    = 8,
    parameter int MAX_BETS     = 4,
    parameter int MONEY_W      = 16,
    parameter int DISP_CYCLES  = 4096,
    parameter int SPIN_TIMEOUT = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [3:0]                    key_value,
    input  logic                          spin_done,
    input  logic [$clog2(NUM_SLOTS)-1:0]  roulette_pos,
    input  logic [MONEY_W-1:0]            current_money,
    output logic                          start_spin,
    output logic                          win_flag,
    output logic                          lose_flag,
    output logic [MONEY_W-1:0]            bet_amount,
    output logic [$clog2(MAX_BETS+1)-1:0] bet_count,
    output logic                          settle_valid,
    output logic [MONEY_W-1:0]            payout,
    output logic                          entry_error,
    output logic                          spin_abort,
    output logic [3:0]                    state
);
    localparam int CW = $clog2(MAX_BETS + 1);
    localparam int DW = $clog2(DISP_CYCLES + 1);
    localparam int AW = MONEY_W + 4;

    state_t        cur, nxt;
    logic [3:0]    nums [MAX_BETS];
    logic [CW-1:0] idx;
    logic [DW-1:0] disp_cnt;
    logic [AW-1:0] amt_new, prod;
    logic          kv, err, hit, dup, amt_ok, cnt_ok, num_ok, last, disp_end, spin_to;

    assign state    = cur;
    assign kv       = key_valid && key_value <= KEY_HASH;
    assign amt_new  = AW'(bet_amount) * AW'(10) + AW'(key_value);
    assign amt_ok   = is_digit(key_value) && amt_new <= AW'(current_money);
    assign cnt_ok   = key_value != 4'd0 && int'(key_value) <= MAX_BETS;
    assign num_ok   = key_value != 4'd0 && int'(key_value) <= NUM_SLOTS && !dup;
    assign last     = idx + CW'(1) == bet_count;
    assign disp_end = disp_cnt == DW'(DISP_CYCLES - 1);
    assign prod     = AW'(bet_amount) * AW'(odds(NUM_SLOTS, int'(bet_count)));

    roulette_bet_match #(.MAX_BETS(MAX_BETS)) u_match (
        .nums       (nums),
        .bet_count  (bet_count),
        .idx        (idx),
        .result_num (4'(roulette_pos) + 4'd1),
        .cand       (key_value),
        .hit        (hit),
        .dup        (dup)
    );

`ifdef ROULETTE_SPIN_TIMEOUT_EN
    localparam int SW = $clog2(SPIN_TIMEOUT + 1);
    logic [SW-1:0] spin_cnt;
    assign spin_to = spin_cnt == SW'(SPIN_TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) spin_cnt <= '0;
        else     spin_cnt <= (cur == S_SPIN_WAIT) ? spin_cnt + SW'(1) : '0;
`else
    logic unused_timeout;
    assign unused_timeout = ^SPIN_TIMEOUT;
    assign spin_to = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;

    always_comb begin
        nxt = cur;
        err = 1'b0;
        case (cur)
            S_IDLE: if (kv) begin
                if (is_star(key_value) && current_money != '0) nxt = S_BET_AMOUNT;
                else err = 1'b1;
            end
            S_BET_AMOUNT: if (kv) begin
                if (is_star(key_value)) begin
                    if (bet_amount != '0) nxt = S_BET_COUNT;
                    else err = 1'b1;
                end else if (!is_hash(key_value) && !amt_ok) err = 1'b1;
            end
            S_BET_COUNT: if (kv) begin
                if (cnt_ok) nxt = S_NUM_INPUT;
                else if (is_hash(key_value)) nxt = S_BET_AMOUNT;
                else err = 1'b1;
            end
            S_NUM_INPUT: if (kv) begin
                if (num_ok && last) nxt = S_START_SPIN;
                else if (!num_ok && !is_hash(key_value)) err = 1'b1;
            end
            S_START_SPIN: nxt = S_SPIN_WAIT;
            S_SPIN_WAIT:  nxt = spin_done ? S_RESULT : spin_to ? S_IDLE : S_SPIN_WAIT;
            S_RESULT:     nxt = hit ? S_WIN_DISP : S_LOSE_DISP;
            S_WIN_DISP, S_LOSE_DISP: nxt = disp_end ? S_SETTLE : cur;
            S_SETTLE:     nxt = S_CHECK_OVER;
            S_CHECK_OVER: nxt = (current_money == '0) ? S_GAME_OVER : S_IDLE;
            S_GAME_OVER: if (kv) begin
                if (is_hash(key_value)) nxt = S_IDLE;
                else err = 1'b1;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_spin   = cur == S_START_SPIN;
        settle_valid = cur == S_SETTLE;
        payout       = (settle_valid && win_flag) ? (|prod[AW-1:MONEY_W] ? '1 : prod[MONEY_W-1:0]) : '0;
        spin_abort   = cur == S_SPIN_WAIT && !spin_done && spin_to;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bet_amount  <= '0;
            bet_count   <= '0;
            idx         <= '0;
            win_flag    <= 1'b0;
            lose_flag   <= 1'b0;
            entry_error <= 1'b0;
            disp_cnt    <= '0;
            for (int i = 0; i < MAX_BETS; i++) nums[i] <= '0;
        end else begin
            entry_error <= err;
            disp_cnt    <= (cur == S_WIN_DISP || cur == S_LOSE_DISP) ? disp_cnt + DW'(1) : '0;
            case (cur)
                S_IDLE: begin
                    bet_amount <= '0;
                    bet_count  <= '0;
                    idx        <= '0;
                    win_flag   <= 1'b0;
                    lose_flag  <= 1'b0;
                    for (int i = 0; i < MAX_BETS; i++) nums[i] <= '0;
                end
                S_BET_AMOUNT: if (kv && (amt_ok || is_hash(key_value)))
                    bet_amount <= is_hash(key_value) ? '0 : amt_new[MONEY_W-1:0];
                S_BET_COUNT: if (kv && cnt_ok) begin
                    bet_count <= CW'(key_value);
                    idx       <= '0;
                end
                S_NUM_INPUT: if (kv && is_hash(key_value)) begin
                    idx <= '0;
                    for (int i = 0; i < MAX_BETS; i++) nums[i] <= '0;
                end else if (kv && num_ok) begin
                    idx <= idx + CW'(1);
                    for (int i = 0; i < MAX_BETS; i++) if (CW'(i) == idx) nums[i] <= key_value;
                end
                S_RESULT: begin
                    win_flag  <= hit;
                    lose_flag <= !hit;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_roulette_game_ctrl.sv
// tb_roulette_game_ctrl: directed self-checking bench for roulette_game_ctrl
module tb_roulette_game_ctrl;
    logic        clk = 1'b0;
    logic        rst, key_valid, spin_done;
    logic [3:0]  key_value;
    logic [2:0]  roulette_pos;
    logic [15:0] current_money;
    logic        start_spin, win_flag, lose_flag, settle_valid, entry_error, spin_abort;
    logic [15:0] bet_amount, payout;
    logic [2:0]  bet_count;
    logic [3:0]  state;
    int          total = 0, bad = 0, n;
    logic        settle_seen;

    roulette_game_ctrl #(.DISP_CYCLES(4), .SPIN_TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_value(key_value),
        .spin_done(spin_done), .roulette_pos(roulette_pos), .current_money(current_money),
        .start_spin(start_spin), .win_flag(win_flag), .lose_flag(lose_flag),
        .bet_amount(bet_amount), .bet_count(bet_count), .settle_valid(settle_valid),
        .payout(payout), .entry_error(entry_error), .spin_abort(spin_abort), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_value = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_st(input logic [3:0] s);
        int c = 0;
        while (state !== s && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    task automatic spin(input logic [2:0] pos);
        roulette_pos = pos;
        spin_done = 1'b1;
        @(negedge clk);
        spin_done = 1'b0;
        chk("result_state", 32'(state), 6);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_value = 4'd0; spin_done = 1'b0;
        roulette_pos = 3'd0; current_money = 16'd100;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_bits", 32'({start_spin, win_flag, lose_flag, settle_valid, entry_error, spin_abort}), 0);
        chk("rst_amount", 32'(bet_amount), 0);
        chk("rst_count", 32'(bet_count), 0);
        chk("rst_payout", 32'(payout), 0);
        rst = 1'b0;
        spin_done = 1'b1;
        @(negedge clk);
        spin_done = 1'b0;
        chk("stray_done", 32'(state), 0);

        // win path: stake 50 on {3,7}, ball on 7
        press(10); chk("idle_star", 32'(state), 1);
        press(5); press(0); chk("amount_50", 32'(bet_amount), 50);
        press(10); chk("to_count", 32'(state), 2);
        press(2); chk("count_2", 32'(bet_count), 2); chk("to_num", 32'(state), 3);
        press(3); press(7);
        chk("start_state", 32'(state), 4); chk("start_pulse", 32'(start_spin), 1);
        @(negedge clk);
        chk("spin_wait", 32'(state), 5); chk("start_once", 32'(start_spin), 0);
        press(1); chk("spin_key_state", 32'(state), 5); chk("spin_key_noerr", 32'(entry_error), 0);
        spin(3'd6);
        @(negedge clk);
        chk("win_flag", 32'(win_flag), 1); chk("lose_clear", 32'(lose_flag), 0);
        n = 0;
        while (state == 4'd7 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("disp_len", 32'(n), 4);
        chk("settle_state", 32'(state), 9);
        chk("settle_valid", 32'(settle_valid), 1);
        chk("win_payout", 32'(payout), 200);
        chk("win_held", 32'(win_flag), 1);
        @(negedge clk);
        chk("settle_once", 32'(settle_valid), 0); chk("check_over", 32'(state), 10);
        @(negedge clk); chk("back_idle", 32'(state), 0);
        @(negedge clk); chk("flag_cleared", 32'(win_flag), 0);

        // loss down to zero balance
        current_money = 16'd30;
        press(10); press(3); press(0); chk("amount_30", 32'(bet_amount), 30);
        press(10); press(1); press(4); chk("start_loss", 32'(state), 4);
        @(negedge clk);
        spin(3'd0);
        wait_st(9);
        chk("lose_flag", 32'(lose_flag), 1); chk("lose_win0", 32'(win_flag), 0);
        chk("lose_payout", 32'(payout), 0); chk("lose_settle", 32'(settle_valid), 1);
        current_money = 16'd0;
        @(negedge clk); chk("loss_check", 32'(state), 10);
        @(negedge clk); chk("game_over", 32'(state), 11);
        press(10); chk("over_star_err", 32'(entry_error), 1); chk("over_stay", 32'(state), 11);
        press(11); chk("over_hash", 32'(state), 0); chk("over_hash_ok", 32'(entry_error), 0);
        press(10); chk("broke_star_err", 32'(entry_error), 1); chk("broke_stay", 32'(state), 0);

        // entry limits against balance 120
        current_money = 16'd120;
        press(10); press(1); press(2); chk("amount_12", 32'(bet_amount), 12);
        press(5); chk("over_bal_err", 32'(entry_error), 1); chk("over_bal_keep", 32'(bet_amount), 12);
        press(11); chk("hash_clear", 32'(bet_amount), 0);
        press(10); chk("zero_star_err", 32'(entry_error), 1); chk("zero_star_stay", 32'(state), 1);
        press(1); press(2); press(0);
        chk("amount_eq_bal", 32'(bet_amount), 120); chk("eq_bal_ok", 32'(entry_error), 0);
        press(10); press(5); chk("count_hi_err", 32'(entry_error), 1); chk("count_hi_stay", 32'(state), 2);
        press(11); chk("count_back", 32'(state), 1); chk("count_back_amt", 32'(bet_amount), 120);
        press(10); press(3); chk("count_3", 32'(bet_count), 3);

        // duplicate and out-of-range numbers
        press(2); chk("num2_ok", 32'(entry_error), 0);
        press(2); chk("dup_err", 32'(entry_error), 1);
        press(9); chk("range_err", 32'(entry_error), 1);
        press(5); chk("num5_state", 32'(state), 3);
        press(6); chk("dup_start", 32'(state), 4); chk("dup_start_pulse", 32'(start_spin), 1);
        @(negedge clk);
        spin(3'd4);
        wait_st(9);
        chk("dup_win", 32'(win_flag), 1); chk("dup_payout", 32'(payout), 240);
        wait_st(0);

        // async reset while displaying a win
        press(10); press(1); press(10); press(1); press(3);
        @(negedge clk);
        spin(3'd2);
        @(negedge clk); chk("disp_before_rst", 32'(state), 7);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0); chk("arst_win", 32'(win_flag), 0);
        chk("arst_amount", 32'(bet_amount), 0); chk("arst_count", 32'(bet_count), 0);
        settle_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            settle_seen = settle_seen | settle_valid;
        end
        chk("arst_no_settle", 32'(settle_seen), 0); chk("arst_idle", 32'(state), 0);

`ifdef ROULETTE_SPIN_TIMEOUT_EN
        press(10); press(1); press(10); press(1); press(3);
        @(negedge clk); chk("to_wait", 32'(state), 5);
        settle_seen = 1'b0;
        repeat (9) begin
            settle_seen = settle_seen | spin_abort;
            @(negedge clk);
        end
        chk("to_early_abort", 32'(settle_seen), 0);
        chk("to_abort", 32'(spin_abort), 1);
        @(negedge clk); chk("to_idle", 32'(state), 0); chk("to_abort_once", 32'(spin_abort), 0);
        press(10); press(1); press(10); press(1); press(3);
        @(negedge clk);
        repeat (9) @(negedge clk);
        roulette_pos = 3'd2;
        spin_done = 1'b1;
        #1 chk("to_done_wins", 32'(spin_abort), 0);
        @(negedge clk);
        spin_done = 1'b0;
        chk("to_done_result", 32'(state), 6);
        wait_st(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/roulette_game_ctrl.md
Name: roulette_game_ctrl

Overview:
- Parametrised keypad-driven roulette game controller.
- Collects bet amount, bet count and bet numbers, triggers the spinner, and evaluates win/lose against the stopped position in a dedicated registered cycle.
- Issues a one-cycle settlement request (debit/payout) to the money manager.
- Generalises slot count, bet depth, money width and display hold time. Adds duplicate-number rejection, an entry-error pulse, and a computed payout.

Parameters:
- NUM_SLOTS, 8, roulette positions; numbers 1..NUM_SLOTS; legal range 2..9 (single keypad digit).
- MAX_BETS, 4, maximum numbers per round; legal range 1..NUM_SLOTS-1.
- MONEY_W, 16, width of all money quantities.
- DISP_CYCLES, 4096, cycles WIN/LOSE display is held (>=1).
- SPIN_TIMEOUT, 1000000, spin watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key_valid  in  1  one-cycle keypad strobe
- key_value  in  4  0..9 digits, 10='*', 11='#', others ignored
- spin_done  in  1  spinner stopped (level or pulse)
- roulette_pos  in  $clog2(NUM_SLOTS)  stopped position, 0-based
- current_money  in  MONEY_W  current balance
- start_spin  out  1  one-cycle spin trigger
- win_flag  out  1  held from RESULT through SETTLE on a win
- lose_flag  out  1  held from RESULT through SETTLE on a loss
- bet_amount  out  MONEY_W  entered stake
- bet_count  out  $clog2(MAX_BETS+1)  numbers chosen
- settle_valid  out  1  one-cycle settlement request
- payout  out  MONEY_W  credit on win (0 on loss); the stake is always debited
- entry_error  out  1  one-cycle pulse on a rejected key
- spin_abort  out  1  one-cycle pulse; stuck 0 unless the optional feature is compiled in
- state  out  4  current state code

Behaviour:
- Reset (async): state=IDLE; every output 0; bet number store cleared.
- State codes: IDLE 0, BET_AMOUNT 1, BET_COUNT 2, NUM_INPUT 3, START_SPIN 4, SPIN_WAIT 5, RESULT 6, WIN_DISP 7, LOSE_DISP 8, SETTLE 9, CHECK_OVER 10, GAME_OVER 11. Unused codes go to IDLE.
- Key handling: a key is acted on only in the cycle key_valid=1. Keys not legal in the current state pulse entry_error and change nothing.
- IDLE:
  - clears bet_amount, bet_count, index, win_flag, lose_flag.
  - '*' with current_money>0 goes to BET_AMOUNT.
  - '*' with balance 0 is an error.
- BET_AMOUNT:
  - digit: new = bet_amount*10+d. Accept only if new<=current_money; otherwise error, value unchanged. No width overflow is possible.
  - '#': clear to 0.
  - '*' with bet_amount>0 goes to BET_COUNT; '*' with 0 is an error.
- BET_COUNT:
  - digit 1..MAX_BETS: latch bet_count, index=0, go to NUM_INPUT.
  - '#' returns to BET_AMOUNT with the amount kept.
- NUM_INPUT:
  - digit 1..NUM_SLOTS not already stored in this round: store it and increment the index.
  - When the last number is stored, go to START_SPIN on the next cycle.
  - A duplicate or out-of-range digit is an error.
  - '#' resets the index to 0 and clears the store.
- START_SPIN: start_spin=1 for exactly one cycle, then SPIN_WAIT.
- SPIN_WAIT: spin_done=1 goes to RESULT. Keys are ignored without an error.
- RESULT:
  - one cycle; compare roulette_pos+1 with stored entries [0..bet_count-1].
  - Register win_flag/lose_flag (exactly one set) and the state change in the same edge, using a combinational match.
  - Next state is WIN_DISP or LOSE_DISP; the display counter is reset.
- WIN_DISP / LOSE_DISP: hold exactly DISP_CYCLES cycles, then SETTLE.
- SETTLE:
  - settle_valid=1 for one cycle.
  - payout = bet_amount*floor(NUM_SLOTS/bet_count), saturated to 2^MONEY_W-1; payout=0 on a loss.
  - Then CHECK_OVER.
- CHECK_OVER: samples current_money one cycle after settle_valid. Balance 0 goes to GAME_OVER, otherwise IDLE. Flags clear in IDLE.
- GAME_OVER: '#' goes to IDLE; all other keys are errors.
- Simultaneous events:
  - key_valid during START_SPIN/RESULT/DISP/SETTLE is ignored, no error.
  - spin_done outside SPIN_WAIT is ignored.
- Reset mid-round: abandons the round with no settlement pulse.

Optional Feature:
- Macro: ROULETTE_SPIN_TIMEOUT_EN.
- Defined: SPIN_WAIT counts cycles. If SPIN_TIMEOUT cycles pass without spin_done, pulse spin_abort for one cycle and go to IDLE with no settlement (stake not debited). spin_done in the same cycle as the timeout wins.
- Undefined: no counter; SPIN_WAIT waits indefinitely; spin_abort tied 0.

Decomposition:
- Package roulette_pkg: state code constants, KEY_STAR=10 and KEY_HASH=11, key-class helper functions.
- Sub-module roulette_bet_match: combinational; inputs are the stored numbers, bet_count and result number; outputs are hit and dup-check for a candidate digit. It is shared by NUM_INPUT and RESULT.

Test Plan:
- Win path, balance 100: keys * 5 0 * 2 3 7, roulette_pos=6 -> start_spin single pulse; win_flag=1 from RESULT onward; settle_valid with payout=200 (50*floor(8/2)); state returns to IDLE.
- Loss to zero, balance 30: stake 30, count 1, number 4, pos=0 -> lose_flag=1; payout=0; with current_money driven to 0 state becomes GAME_OVER (11); '#' returns to IDLE.
- Entry limits, balance 120: digits 1 2 5 -> third digit raises entry_error and bet_amount stays 12; '*' with amount 0 raises an error.
- Duplicates, count 3: numbers 2 2 9 5 6 -> second 2 and 9 each pulse entry_error; stored set is {2,5,6}; spin starts after 6.
- Display timing: with DISP_CYCLES=4, exactly 4 cycles in WIN_DISP before SETTLE; async rst in WIN_DISP -> all outputs 0 immediately, no settle_valid.
- With ROULETTE_SPIN_TIMEOUT_EN and SPIN_TIMEOUT=10: no spin_done -> spin_abort pulses in cycle 10 and state goes to IDLE; spin_done on cycle 10 -> RESULT, no abort.
